// File: rtl/pc_pkg.sv
// Shared types for the PC sequencer: the operation enum and its priority selector.
package pc_pkg;

  typedef enum logic [2:0] {PC_HOLD, PC_RET, PC_CALL, PC_JUMP, PC_BRANCH, PC_INC} pc_op_t;

  // Only one operation wins per edge: stall > ret > call > jump > branch > increment.
  function automatic pc_op_t pc_select(input logic stall, input logic ret, input logic call,
                                       input logic jump, input logic branch);
    if (stall) return PC_HOLD;
    else if (ret) return PC_RET;
    else if (call) return PC_CALL;
    else if (jump) return PC_JUMP;
    else if (branch) return PC_BRANCH;
    else return PC_INC;
  endfunction

endpackage

// File: rtl/return_stack.sv
// Return-address LIFO: register array plus a count, only the top entry is visible.
module return_stack #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned STACK_DEPTH = 4,
  localparam int unsigned CountWidth = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] push_data,
  output logic [ADDR_WIDTH-1:0] top_data,
  output logic [CountWidth-1:0] count,
  output logic                  full,
  output logic                  empty
);

  logic [ADDR_WIDTH-1:0] entries_q [STACK_DEPTH];
  logic [CountWidth-1:0] count_q;

  assign count = count_q;
  assign full  = (count_q == CountWidth'(STACK_DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    top_data = '0;
    for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
      if (count_q == CountWidth'(i + 1)) top_data = entries_q[i];
    end
  end

  // Push on full and pop on empty are dropped; the caller reports them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) entries_q[i] <= '0;
    end else if (pop && !empty) begin
      count_q <= count_q - CountWidth'(1);
    end else if (push && !full) begin
      for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
        if (count_q == CountWidth'(i)) entries_q[i] <= push_data;
      end
      count_q <= count_q + CountWidth'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-address sequencer with stall, branch, jump and call/return via a return stack.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned RESET_VECTOR = 0,
  parameter int unsigned INCREMENT    = 1,
  parameter int unsigned STACK_DEPTH  = 4,
  localparam int unsigned CountWidth  = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  branch,
  input  logic [ADDR_WIDTH-1:0] branch_offset,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  input  logic                  call,
  input  logic                  ret,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [CountWidth-1:0] stack_count,
  output logic                  stack_overflow,
  output logic                  stack_underflow
);

  pc_op_t                op;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, seq, top_data;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  full, empty;

  assign op  = pc_select(stall, ret, call, jump, branch);
  assign seq = addr_q + ADDR_WIDTH'(INCREMENT);

  always_comb begin
    addr_d = addr_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    unique case (op)
      PC_HOLD: addr_d = addr_q;
      PC_RET: begin
        if (empty) begin
          addr_d = seq;
          unf_d  = 1'b1;
        end else begin
          addr_d = top_data;
        end
      end
      PC_CALL: begin
        addr_d = jump_target;
        if (full) ovf_d = 1'b1;
      end
      PC_JUMP:   addr_d = jump_target;
      // Same-width add is modulo 2^ADDR_WIDTH, so the offset acts as signed.
      PC_BRANCH: addr_d = seq + branch_offset;
      PC_INC:    addr_d = seq;
      default:   addr_d = seq;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q <= ADDR_WIDTH'(RESET_VECTOR);
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  return_stack #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_return_stack (
    .clock    (clock),
    .reset    (reset),
    .push     (op == PC_CALL),
    .pop      (op == PC_RET),
    .push_data(seq),
    .top_data (top_data),
    .count    (stack_count),
    .full     (full),
    .empty    (empty)
  );

  assign address         = addr_q;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, nested call/return sequence, random vs model.
module tb_pc_sequencer;

  localparam int Depth = 4;
  localparam int CW    = $clog2(Depth + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic          stall, branch, jump, call, ret;
  logic [7:0]    branch_offset, jump_target;
  logic [7:0]    address;
  logic [CW-1:0] stack_count;
  logic          stack_overflow, stack_underflow;

  always #5 clock = ~clock;

  pc_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .branch         (branch),
    .branch_offset  (branch_offset),
    .jump           (jump),
    .jump_target    (jump_target),
    .call           (call),
    .ret            (ret),
    .address        (address),
    .stack_count    (stack_count),
    .stack_overflow (stack_overflow),
    .stack_underflow(stack_underflow)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: address as an integer, return stack as a queue.
  int m_addr;
  int m_stack[$];
  int m_ovf, m_unf;

  typedef struct {
    logic       s, r, c, j, b;
    logic [7:0] off, tgt, exp_addr;
    int         exp_cnt;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input logic s, r, c, j, b, input logic [7:0] off, tgt, ea,
                         input int ec);
    vec_t v;
    v.s = s; v.r = r; v.c = c; v.j = j; v.b = b;
    v.off = off; v.tgt = tgt; v.exp_addr = ea; v.exp_cnt = ec;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_addr = 0;
    m_stack.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic model_step(input logic s, r, c, j, b, input logic [7:0] off, tgt);
    int seq;
    seq = (m_addr + 1) % 256;
    if (s) begin
    end else if (r) begin
      if (m_stack.size() > 0) m_addr = m_stack.pop_back();
      else begin
        m_addr = seq;
        m_unf  = 1;
      end
    end else if (c) begin
      if (m_stack.size() < Depth) m_stack.push_back(seq);
      else m_ovf = 1;
      m_addr = int'(tgt);
    end else if (j) m_addr = int'(tgt);
    else if (b) m_addr = (seq + int'(off)) % 256;
    else m_addr = seq;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_addr"}, int'(address), m_addr);
    check({tag, "_count"}, int'(stack_count), m_stack.size());
    check({tag, "_ovf"}, int'(stack_overflow), m_ovf);
    check({tag, "_unf"}, int'(stack_underflow), m_unf);
  endtask

  // Called just after a rising edge; drives inputs, takes one edge, samples 1 ns later.
  task automatic step(input logic s, r, c, j, b, input logic [7:0] off, tgt);
    stall = s; ret = r; call = c; jump = j; branch = b;
    branch_offset = off; jump_target = tgt;
    @(posedge clock);
    #1;
    model_step(s, r, c, j, b, off, tgt);
  endtask

  // Asserts reset between edges, checks it acts without a clock, holds it over one edge.
  task automatic async_reset(input string tag);
    reset = 1'b1;
    #2;
    model_reset();
    check_model({tag, "_async"});
    @(posedge clock);
    #1;
    check_model({tag, "_held"});
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    stall = 0; ret = 0; call = 0; jump = 0; branch = 0;
    branch_offset = '0; jump_target = '0;
    model_reset();
    @(posedge clock);
    #1;
    check_model("reset");
    reset = 1'b0;

    // Directed table: expectations are literal values, not model outputs.
    //      s  r  c  j  b  off    tgt    addr   cnt
    add_vec(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h01, 0);
    add_vec(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h02, 0);
    add_vec(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h03, 0);
    add_vec(0, 0, 0, 1, 0, 8'h00, 8'h10, 8'h10, 0);
    add_vec(0, 0, 0, 0, 1, 8'hFC, 8'h00, 8'h0D, 0);
    add_vec(0, 0, 0, 1, 1, 8'h05, 8'h80, 8'h80, 0);
    add_vec(0, 0, 0, 1, 0, 8'h00, 8'h20, 8'h20, 0);
    add_vec(0, 0, 1, 0, 0, 8'h00, 8'h40, 8'h40, 1);
    add_vec(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h41, 1);
    add_vec(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h42, 1);
    add_vec(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h21, 0);
    add_vec(0, 0, 0, 1, 0, 8'h00, 8'h20, 8'h20, 0);
    add_vec(0, 0, 1, 0, 0, 8'h00, 8'h40, 8'h40, 1);
    add_vec(0, 1, 1, 0, 0, 8'h00, 8'h55, 8'h21, 0);
    add_vec(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h22, 0);
    add_vec(0, 0, 0, 1, 0, 8'h00, 8'hFE, 8'hFE, 0);
    add_vec(1, 0, 0, 1, 0, 8'h00, 8'h11, 8'hFE, 0);
    add_vec(1, 0, 1, 0, 1, 8'h07, 8'h33, 8'hFE, 0);
    add_vec(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'hFF, 0);
    add_vec(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0);
    add_vec(0, 0, 0, 0, 1, 8'h7F, 8'h00, 8'h80, 0);

    foreach (vecs[i]) begin
      step(vecs[i].s, vecs[i].r, vecs[i].c, vecs[i].j, vecs[i].b, vecs[i].off, vecs[i].tgt);
      check($sformatf("vec%0d_addr", i), int'(address), int'(vecs[i].exp_addr));
      check($sformatf("vec%0d_count", i), int'(stack_count), vecs[i].exp_cnt);
      check($sformatf("vec%0d_flags", i), int'({stack_overflow, stack_underflow}), 0);
    end

    step(0, 0, 0, 0, 0, 8'h00, 8'h00);
    async_reset("midcount");

    // Nested calls past depth, then returns past empty.
    step(0, 0, 0, 1, 0, 8'h00, 8'h10);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 1, 0, 0, 8'h00, 8'(8'h20 + 8'(k * 16)));
      check($sformatf("call%0d_addr", k), int'(address), 8'h20 + k * 16);
      check($sformatf("call%0d_count", k), int'(stack_count), (k < 4) ? k + 1 : 4);
      check($sformatf("call%0d_ovf", k), int'(stack_overflow), (k == 4) ? 1 : 0);
    end
    begin
      int exp_ret[5] = '{8'h41, 8'h31, 8'h21, 8'h11, 8'h12};
      for (int k = 0; k < 5; k++) begin
        step(0, 1, 0, 0, 0, 8'h00, 8'h00);
        check($sformatf("ret%0d_addr", k), int'(address), exp_ret[k]);
        check($sformatf("ret%0d_count", k), int'(stack_count), (k < 4) ? 3 - k : 0);
        check($sformatf("ret%0d_unf", k), int'(stack_underflow), (k == 4) ? 1 : 0);
      end
    end
    for (int k = 0; k < 3; k++) begin
      step(0, 0, (k == 1), 0, 0, 8'h00, 8'h90);
      check($sformatf("sticky%0d", k), int'({stack_overflow, stack_underflow}), 3);
    end
    stall = 0; ret = 0; call = 1; jump = 1; jump_target = 8'hAA;
    async_reset("midop");

    // Randomised run against the model, with occasional asynchronous resets.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        async_reset($sformatf("rnd%0d_rst", n));
      end else begin
        step(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)),
             8'($urandom_range(0, 255)));
        check_model($sformatf("rnd%0d", n));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
